// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the clock-domain-crossing synchronizers.
package cdc_pkg;

    localparam int unsigned CDC_MIN_STAGES = 2;
    localparam int unsigned CDC_MAX_STAGES = 4;
    localparam int unsigned CDC_MIN_WIDTH  = 1;
    localparam int unsigned CDC_MAX_WIDTH  = 32;

    function automatic logic cdc_stages_legal(input int unsigned stages);
        return (stages >= CDC_MIN_STAGES) && (stages <= CDC_MAX_STAGES);
    endfunction

    function automatic logic cdc_width_legal(input int unsigned width);
        return (width >= CDC_MIN_WIDTH) && (width <= CDC_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit flop chain into the clkb domain; every stage resets to RESET_VAL.
module cdc_sync_bit
    import cdc_pkg::*;
#(
    parameter int unsigned STAGES    = CDC_MIN_STAGES,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clkb,
    input  logic rstb,
    input  logic d_i,
    output logic q_o
);

    // Kept as a plain shift chain so placement keeps the flops adjacent and unretimed.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clkb or negedge rstb) begin
        if (!rstb) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_synchronizer.sv
// Per-bit multi-stage synchronizer for levels, toggles and quasi-static words.
module cdc_synchronizer
    import cdc_pkg::*;
#(
    parameter int unsigned     WIDTH     = 1,
    parameter int unsigned     STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clkb,
    input  logic             rstb,
    input  logic [WIDTH-1:0] siga,
    output logic [WIDTH-1:0] sigb
);

    if (!cdc_stages_legal(STAGES)) begin : g_bad_stages
        $error("cdc_synchronizer: STAGES=%0d outside %0d..%0d",
               STAGES, CDC_MIN_STAGES, CDC_MAX_STAGES);
    end

    if (!cdc_width_legal(WIDTH)) begin : g_bad_width
        $error("cdc_synchronizer: WIDTH=%0d outside %0d..%0d",
               WIDTH, CDC_MIN_WIDTH, CDC_MAX_WIDTH);
    end

    // Bits are independent; no coherency across the word.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cdc_sync_bit #(
            .STAGES    (STAGES),
            .RESET_VAL (RESET_VAL[i])
        ) u_sync_bit (
            .clkb (clkb),
            .rstb (rstb),
            .d_i  (siga[i]),
            .q_o  (sigb[i])
        );
    end

endmodule

// File: tb/tb_cdc_synchronizer.sv
// Scoreboard bench: expected per-edge values queued at drive time, popped on each falling clkb.
`timescale 1ns/1ps
module tb_cdc_synchronizer;

    logic       clkb = 1'b0;
    logic       clka = 1'b0;
    logic       rstb = 1'b1;
    logic       rst8 = 1'b1;
    logic [7:0] siga8 = 8'h3C;
    logic [7:0] sigb8;
    logic       siga1 = 1'b0;
    logic       sigb1;
    logic       siga4 = 1'b0;
    logic       sigb4;
    logic       siga_t = 1'b0;
    logic       sigb_t;

    int n_checks = 0;
    int n_errors = 0;

    // 61.44 MHz destination clock; source clock deliberately unrelated.
    always #8.138 clkb = ~clkb;
    always #23.5  clka = ~clka;

    cdc_synchronizer #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'hA5)) u_dut8 (
        .clkb (clkb), .rstb (rst8), .siga (siga8), .sigb (sigb8)
    );
    cdc_synchronizer #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0)) u_dut1 (
        .clkb (clkb), .rstb (rstb), .siga (siga1), .sigb (sigb1)
    );
    cdc_synchronizer #(.WIDTH(1), .STAGES(4), .RESET_VAL(1'b0)) u_dut4 (
        .clkb (clkb), .rstb (rstb), .siga (siga4), .sigb (sigb4)
    );
    cdc_synchronizer #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0)) u_dut_tgl (
        .clkb (clkb), .rstb (rstb), .siga (siga_t), .sigb (sigb_t)
    );

    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      tag;
    } sb_entry_t;

    sb_entry_t  sb[$];
    sb_entry_t  sb_e;
    logic [7:0] sb_act;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clkb) begin
        if (sb.size() != 0) begin
            sb_e = sb.pop_front();
            case (sb_e.sel)
                8:       sb_act = sigb8;
                1:       sb_act = {7'b0, sigb1};
                4:       sb_act = {7'b0, sigb4};
                default: sb_act = 8'hxx;
            endcase
            check_val(sb_e.tag, {24'b0, sb_act}, {24'b0, sb_e.exp});
        end
    end

    task automatic push(input int sel, input logic [7:0] v, input string tag);
        sb_entry_t e;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clkb);
        #1;
        check_val("sb_drain", sb.size(), 0);
    endtask

    task automatic drive(input int sel, input logic [7:0] v);
        case (sel)
            8:       siga8 = v;
            1:       siga1 = v[0];
            4:       siga4 = v[0];
            default: ;
        endcase
    endtask

    // Drive 1 ns after an edge: old value for `stages` samples, then the new one.
    task automatic step(input int sel, input int stages, input logic [7:0] old_v,
                        input logic [7:0] new_v, input int nhold, input string tag);
        @(posedge clkb);
        #1;
        drive(sel, new_v);
        for (int i = 0; i < stages; i++) push(sel, old_v, {tag, "_old"});
        for (int i = 0; i < nhold; i++) push(sel, new_v, {tag, "_new"});
        wait_drain();
    endtask

    // Receiver-side toggle edge detector.
    logic tgl_held_q = 1'b0;
    logic tgl_en = 1'b0;
    int   tgl_events = 0;
    always @(posedge clkb) begin
        tgl_held_q <= sigb_t;
        if (tgl_en && (sigb_t != tgl_held_q)) tgl_events <= tgl_events + 1;
    end

    initial begin
        #2;
        rst8 = 1'b0;
        rstb = 1'b0;
        #1;
        check_val("rst_async8", {24'b0, sigb8}, 32'hA5);
        check_val("rst_async1", {31'b0, sigb1}, 32'h0);

        // Reset held while the clock runs.
        for (int i = 0; i < 6; i++) push(8, 8'hA5, "rst_hold");
        wait_drain();

        @(posedge clkb);
        #1;
        rst8 = 1'b1;
        rstb = 1'b1;
        for (int i = 0; i < 2; i++) push(8, 8'hA5, "rel_wait");
        for (int i = 0; i < 4; i++) push(8, 8'h3C, "rel_val");
        wait_drain();

        step(1, 2, 8'd0, 8'd1, 4, "lat2_rise");
        step(1, 2, 8'd1, 8'd0, 4, "lat2_fall");
        step(4, 4, 8'd0, 8'd1, 6, "lat4_rise");
        step(4, 4, 8'd1, 8'd0, 4, "lat4_fall");

        // Reset mid-flight with siga held high.
        step(1, 2, 8'd0, 8'd1, 3, "mid_pre");
        @(posedge clkb);
        #1;
        rstb = 1'b0;
        #1;
        check_val("mid_async", {31'b0, sigb1}, 32'h0);
        #2;
        rstb = 1'b1;
        for (int i = 0; i < 2; i++) push(1, 8'd0, "mid_wait");
        for (int i = 0; i < 3; i++) push(1, 8'd1, "mid_rise");
        wait_drain();

        step(8, 2, 8'h3C, 8'd50, 4, "bus_50");
        step(8, 2, 8'd50, 8'd200, 8, "bus_200");

        tgl_en = 1'b1;
        for (int t = 0; t < 100; t++) begin
            repeat (5) @(posedge clka);
            siga_t = ~siga_t;
        end
        repeat (10) @(posedge clkb);
        #1;
        tgl_en = 1'b0;
        check_val("tgl_events", tgl_events, 100);
        check_val("tgl_level", {31'b0, sigb_t}, {31'b0, siga_t});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
